// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 hazard / redirect controller.
package hazard_pkg;

    // Controller modes: normal issue, or killing wrong-path slots after a redirect.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Encoding of addi x0,x0,0 loaded into ID->EX when a bubble is inserted.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // x0 is hardwired to zero, so it is never a real dependency.
    localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/sb_shift.sv
// Writeback scoreboard: a WB_DEPTH-deep shift register of in-flight destination
// registers, with two combinational lookup ports for the ID source operands.
module sb_shift
    import hazard_pkg::*;
#(
    parameter int WB_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    output logic       match1_o,
    output logic       match2_o
);

    logic [WB_DEPTH-1:0] v_q;
    logic [4:0]          rd_q [WB_DEPTH];
    logic                hit1;
    logic                hit2;

    // Advance every in-flight write one stage per cycle; the oldest falls off after its write edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < WB_DEPTH; k++) begin
                rd_q[k] <= REG_ZERO;
            end
        end else begin
            v_q[0]  <= issue_i;
            rd_q[0] <= rd_i;
            for (int k = 1; k < WB_DEPTH; k++) begin
                v_q[k]  <= v_q[k-1];
                rd_q[k] <= rd_q[k-1];
            end
        end
    end

    // Any valid entry naming the source is pending, including the one writing this edge.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (v_q[k] && (rd_q[k] == rs1_i)) hit1 = 1'b1;
            if (v_q[k] && (rd_q[k] == rs2_i)) hit2 = 1'b1;
        end
        match1_o = hit1 && (rs1_i != REG_ZERO);
        match2_o = hit2 && (rs2_i != REG_ZERO);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and redirect controller for the five-stage RV32 pipeline: RAW stalls
// from the writeback scoreboard, wrong-path flushing after taken branches,
// and saturating stall / flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WB_DEPTH    = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wr_en,
    input  logic             ex_redirect,
    output logic             pc_hold,
    output logic             id_bubble,
    output logic             if_kill,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int             FCW        = $clog2(FLUSH_DEPTH) + 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_DEPTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [FCW-1:0]   fcnt_q;
    logic [FCW-1:0]   fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;
    logic             hit1;
    logic             hit2;
    logic             hazard;
    logic             issue;

    sb_shift #(
        .WB_DEPTH (WB_DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .issue_i  (issue),
        .rd_i     (id_rd),
        .rs1_i    (id_rs1),
        .rs2_i    (id_rs2),
        .match1_o (hit1),
        .match2_o (hit2)
    );

    // Stall decision plus pipeline control; a redirect overrides a stall because the stalled instruction is wrong-path.
    always_comb begin
        hazard    = id_valid && (state_q == RUN) &&
                    ((id_use_rs1 && hit1) || (id_use_rs2 && hit2));
        pc_hold   = 1'b0;
        id_bubble = 1'b0;
        if_kill   = 1'b0;
        if (!rst) begin
            pc_hold   = hazard && !ex_redirect;
            id_bubble = hazard || ex_redirect || (state_q == FLUSH);
            if_kill   = ex_redirect || (state_q == FLUSH);
        end
        issue = id_valid && id_wr_en && (id_rd != REG_ZERO) && !id_bubble;
    end

    // Redirect sequencing and the saturating performance counters.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                    if (FLUSH_DEPTH > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q - FCW'(1);
                if (fcnt_q <= FCW'(1)) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
        if (pc_hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State registers; reset drops any redirect in progress and clears the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // EX always holds a bubble while flushing, so it cannot resolve another branch.
    no_redirect_in_flush: assert property (@(posedge clk) disable iff (rst)
        !((state_q == FLUSH) && ex_redirect));

endmodule
